// File: rtl/dot_arbiter.sv
// Shares one 3-element dot-product unit among NUM_REQ requesters: round-robin
// issue with a registered grant, and a tag FIFO that steers results back in issue order.
module dot_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ*96-1:0]         req_x,
  input  logic [NUM_REQ*96-1:0]         req_y,
  input  logic [NUM_REQ-1:0]            req_empty,
  output logic [NUM_REQ-1:0]            req_rd_en,
  output logic [95:0]                   dot_x,
  output logic [95:0]                   dot_y,
  output logic                          dot_in_empty,
  input  logic                          dot_in_rd_en,
  input  logic signed [31:0]            dot_out,
  input  logic                          dot_out_empty,
  output logic                          dot_out_rd_en,
  output logic signed [31:0]            rsp_data,
  output logic [NUM_REQ-1:0]            rsp_wr_en,
  input  logic [NUM_REQ-1:0]            rsp_full,
  output logic [$clog2(TAG_DEPTH):0]    outstanding,
  output logic                          err_orphan
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int PTR_W  = $clog2(TAG_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DATA_W = 32;
  localparam int VEC_W  = 3 * DATA_W;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_orphan_q, err_orphan_d;
  logic [IDX_W-1:0] tag_mem_q [TAG_DEPTH];
  logic [IDX_W-1:0] tag_mem_d [TAG_DEPTH];

  logic [IDX_W-1:0] pick;
  logic             any_req;
  logic             tag_full;
  logic [IDX_W-1:0] head;
  logic             push;
  logic             pop;

  // Round-robin scan starting at rr_ptr; walking offsets downward lets the
  // smallest offset overwrite any later candidate.
  always_comb begin
    int idx;
    idx     = 0;
    pick    = '0;
    any_req = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!req_empty[idx]) begin
        pick    = IDX_W'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign tag_full = (count_q == CNT_W'(TAG_DEPTH));
  assign head     = tag_mem_q[rd_ptr_q];
  assign push     = (state_q == OFFER) && dot_in_rd_en;
  assign pop      = !dot_out_empty && (count_q != '0) && !rsp_full[head];

  assign dot_in_empty  = (state_q != OFFER);
  assign dot_x         = req_x[int'(grant_q)*VEC_W +: VEC_W];
  assign dot_y         = req_y[int'(grant_q)*VEC_W +: VEC_W];
  assign req_rd_en     = push ? (NUM_REQ'(1) << grant_q) : '0;
  assign dot_out_rd_en = pop;
  assign rsp_wr_en     = pop ? (NUM_REQ'(1) << head) : '0;
  assign rsp_data      = dot_out;
  assign outstanding   = count_q;
  assign err_orphan    = err_orphan_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (any_req && !tag_full) begin
          grant_d = pick;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (dot_in_rd_en) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag FIFO bookkeeping; push is gated upstream by tag_full, pop by count != 0.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (pop && !push) count_d = count_q - CNT_W'(1);
    tag_mem_d = tag_mem_q;
    if (push) tag_mem_d[wr_ptr_q] = grant_q;
    err_orphan_d = err_orphan_q | (!dot_out_empty && (count_q == '0));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Tag storage carries no reset; entries are only read below count_q.
  always_ff @(posedge clock) begin
    tag_mem_q <= tag_mem_d;
  end

endmodule

// File: tb/tb_dot_arbiter.sv
// Directed bench for dot_arbiter: per-cycle vector table plus hand-written
// reset-mid-operation and orphan sequences.
module tb_dot_arbiter;

  localparam int NR = 4;
  localparam int TD = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NR*96-1:0] req_x;
  logic [NR*96-1:0] req_y;
  logic [NR-1:0]    req_empty = '1;
  logic [NR-1:0]    req_rd_en;
  logic [95:0]      dot_x;
  logic [95:0]      dot_y;
  logic             dot_in_empty;
  logic             dot_in_rd_en = 1'b0;
  logic signed [31:0] dot_out = '0;
  logic             dot_out_empty = 1'b1;
  logic             dot_out_rd_en;
  logic signed [31:0] rsp_data;
  logic [NR-1:0]    rsp_wr_en;
  logic [NR-1:0]    rsp_full = '0;
  logic [2:0]       outstanding;
  logic             err_orphan;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] x_val [NR][3];

  dot_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(TD)) dut (
    .clock(clock), .reset(reset),
    .req_x(req_x), .req_y(req_y), .req_empty(req_empty), .req_rd_en(req_rd_en),
    .dot_x(dot_x), .dot_y(dot_y), .dot_in_empty(dot_in_empty), .dot_in_rd_en(dot_in_rd_en),
    .dot_out(dot_out), .dot_out_empty(dot_out_empty), .dot_out_rd_en(dot_out_rd_en),
    .rsp_data(rsp_data), .rsp_wr_en(rsp_wr_en), .rsp_full(rsp_full),
    .outstanding(outstanding), .err_orphan(err_orphan)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [3:0]  re;
    logic        ird;
    logic        oe;
    logic [3:0]  rf;
    logic [31:0] dout;
    logic        e_ie;
    int          e_g;
    logic [3:0]  e_rrd;
    logic        e_ord;
    logic [3:0]  e_wr;
    logic [2:0]  e_out;
    logic        e_orph;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [3:0] re, logic ird, logic oe, logic [3:0] rf,
                              logic [31:0] dout, logic e_ie, int e_g, logic [3:0] e_rrd,
                              logic e_ord, logic [3:0] e_wr, logic [2:0] e_out, logic e_orph);
    vec_t v;
    v.rst = rst; v.re = re; v.ird = ird; v.oe = oe; v.rf = rf; v.dout = dout;
    v.e_ie = e_ie; v.e_g = e_g; v.e_rrd = e_rrd; v.e_ord = e_ord; v.e_wr = e_wr;
    v.e_out = e_out; v.e_orph = e_orph;
    return v;
  endfunction

  function automatic logic [95:0] exp_x(int g);
    return {x_val[g][2], x_val[g][1], x_val[g][0]};
  endfunction

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_offer(string tag, int g);
    chk({tag, " dot_in_empty"}, 96'(dot_in_empty), 96'(0));
    chk({tag, " dot_x"}, dot_x, exp_x(g));
    chk({tag, " dot_y"}, dot_y, {32'd1024, 32'd1024, 32'd1024});
  endtask

  initial begin
    for (int r = 0; r < NR; r++)
      for (int e = 0; e < 3; e++) begin
        x_val[r][e] = (r == 2) ? 32'((e + 1) * 1024) : 32'((e + 1) * 1024 + (r + 1) * 7);
        req_x[r*96 + e*32 +: 32] = x_val[r][e];
        req_y[r*96 + e*32 +: 32] = 32'd1024;
      end

    // Single requester r2: 1.0*1+2.0*1+3.0*1 = 6.0 in Q10 = 6144
    tbl.push_back(mk(1, 4'hF, 0, 1, 4'h0, 0,    1, 0, 4'h0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(0, 4'b1011, 0, 1, 4'h0, 0, 1, 0, 4'h0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(0, 4'b1011, 1, 1, 4'h0, 0, 0, 2, 4'b0100, 0, 4'h0, 0, 0));
    tbl.push_back(mk(0, 4'hF, 0, 1, 4'h0, 0,    1, 0, 4'h0, 0, 4'h0, 1, 0));
    tbl.push_back(mk(0, 4'hF, 0, 0, 4'h0, 6144, 1, 0, 4'h0, 1, 4'b0100, 1, 0));
    tbl.push_back(mk(0, 4'hF, 0, 1, 4'h0, 0,    1, 0, 4'h0, 0, 4'h0, 0, 0));
    // Round robin from a fresh reset: grants 0,1,2,3,0,1 two cycles apart
    tbl.push_back(mk(1, 4'hF, 0, 1, 4'h0, 0,    1, 0, 4'h0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 4'h0, 0,    1, 0, 4'h0, 0, 4'h0, 0, 0));
    for (int i = 0; i < 6; i++) begin
      tbl.push_back(mk(0, 4'h0, 1, 1, 4'h0, 0, 0, i % 4, 4'(1 << (i % 4)), 0, 4'h0, 0, 0));
      tbl.push_back(mk(0, (i == 5) ? 4'hF : 4'h0, (i == 5) ? 1'b0 : 1'b1, 0, 4'h0, 32'(1000 + i),
                       1, 0, 4'h0, 1, 4'(1 << (i % 4)), 1, 0));
    end
    // Back-pressure: tags [1,3] queued, rsp_full[1] blocks both
    tbl.push_back(mk(0, 4'b1101, 0, 1, 4'h0, 0, 1, 0, 4'h0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(0, 4'b1101, 1, 1, 4'h0, 0, 0, 1, 4'b0010, 0, 4'h0, 0, 0));
    tbl.push_back(mk(0, 4'b0111, 0, 1, 4'h0, 0, 1, 0, 4'h0, 0, 4'h0, 1, 0));
    tbl.push_back(mk(0, 4'b0111, 1, 1, 4'h0, 0, 0, 3, 4'b1000, 0, 4'h0, 1, 0));
    tbl.push_back(mk(0, 4'hF, 0, 0, 4'b0010, 111, 1, 0, 4'h0, 0, 4'h0, 2, 0));
    tbl.push_back(mk(0, 4'hF, 0, 0, 4'b0010, 111, 1, 0, 4'h0, 0, 4'h0, 2, 0));
    tbl.push_back(mk(0, 4'hF, 0, 0, 4'h0, 111,    1, 0, 4'h0, 1, 4'b0010, 2, 0));
    tbl.push_back(mk(0, 4'hF, 0, 0, 4'h0, 333,    1, 0, 4'h0, 1, 4'b1000, 1, 0));
    tbl.push_back(mk(0, 4'hF, 0, 1, 4'h0, 0,      1, 0, 4'h0, 0, 4'h0, 0, 0));
    // Tag full at TAG_DEPTH=4, then free one slot
    tbl.push_back(mk(0, 4'h0, 1, 1, 4'h0, 0,  1, 0, 4'h0, 0, 4'h0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 1, 4'h0, 0,  0, 0, 4'b0001, 0, 4'h0, 0, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'hF, 77, 1, 0, 4'h0, 0, 4'h0, 1, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'hF, 77, 0, 1, 4'b0010, 0, 4'h0, 1, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'hF, 77, 1, 0, 4'h0, 0, 4'h0, 2, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'hF, 77, 0, 2, 4'b0100, 0, 4'h0, 2, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'hF, 77, 1, 0, 4'h0, 0, 4'h0, 3, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'hF, 77, 0, 3, 4'b1000, 0, 4'h0, 3, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'hF, 77, 1, 0, 4'h0, 0, 4'h0, 4, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'hF, 77, 1, 0, 4'h0, 0, 4'h0, 4, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'b1110, 77, 1, 0, 4'h0, 1, 4'b0001, 4, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'hF, 77, 1, 0, 4'h0, 0, 4'h0, 3, 0));
    tbl.push_back(mk(0, 4'h0, 1, 0, 4'hF, 77, 0, 0, 4'b0001, 0, 4'h0, 3, 0));
    tbl.push_back(mk(0, 4'hF, 0, 0, 4'hF, 77, 1, 0, 4'h0, 0, 4'h0, 4, 0));

    foreach (tbl[i]) begin
      @(negedge clock);
      reset = tbl[i].rst; req_empty = tbl[i].re; dot_in_rd_en = tbl[i].ird;
      dot_out_empty = tbl[i].oe; rsp_full = tbl[i].rf; dot_out = tbl[i].dout;
      #1;
      chk($sformatf("v%0d dot_in_empty", i), 96'(dot_in_empty), 96'(tbl[i].e_ie));
      if (!tbl[i].e_ie) chk($sformatf("v%0d dot_x", i), dot_x, exp_x(tbl[i].e_g));
      chk($sformatf("v%0d req_rd_en", i), 96'(req_rd_en), 96'(tbl[i].e_rrd));
      chk($sformatf("v%0d dot_out_rd_en", i), 96'(dot_out_rd_en), 96'(tbl[i].e_ord));
      chk($sformatf("v%0d rsp_wr_en", i), 96'(rsp_wr_en), 96'(tbl[i].e_wr));
      chk($sformatf("v%0d outstanding", i), 96'(outstanding), 96'(tbl[i].e_out));
      chk($sformatf("v%0d err_orphan", i), 96'(err_orphan), 96'(tbl[i].e_orph));
      chk($sformatf("v%0d rsp_data", i), 96'(rsp_data), 96'(tbl[i].dout));
    end

    // Reset while OFFER is held with three tags outstanding
    @(negedge clock);
    reset = 1; req_empty = 4'hF; dot_in_rd_en = 0; dot_out_empty = 1; rsp_full = 0;
    @(negedge clock);
    reset = 0; req_empty = 4'h0; dot_in_rd_en = 1;
    repeat (6) @(negedge clock);
    dot_in_rd_en = 0;
    @(negedge clock);
    #1;
    chk_offer("midop pre", 3);
    chk("midop pre outstanding", 96'(outstanding), 96'(3));
    reset = 1; dot_in_rd_en = 1;
    #1;
    chk("midop rst dot_in_empty", 96'(dot_in_empty), 96'(1));
    chk("midop rst outstanding", 96'(outstanding), 96'(0));
    chk("midop rst req_rd_en", 96'(req_rd_en), 96'(0));
    @(negedge clock);
    reset = 0; req_empty = 4'b0101; dot_in_rd_en = 0;
    #1;
    chk("midop idle dot_in_empty", 96'(dot_in_empty), 96'(1));
    @(negedge clock);
    #1;
    chk_offer("midop regrant", 1);

    // Orphan result: sticky flag, never popped
    @(negedge clock);
    reset = 1; req_empty = 4'hF;
    #1;
    chk("orphan rst", 96'(err_orphan), 96'(0));
    @(negedge clock);
    reset = 0; dot_out_empty = 0; dot_out = 555;
    #1;
    chk("orphan pre", 96'(err_orphan), 96'(0));
    chk("orphan pre rd_en", 96'(dot_out_rd_en), 96'(0));
    @(negedge clock);
    #1;
    chk("orphan set", 96'(err_orphan), 96'(1));
    chk("orphan rd_en", 96'(dot_out_rd_en), 96'(0));
    chk("orphan wr_en", 96'(rsp_wr_en), 96'(0));
    @(negedge clock);
    dot_out_empty = 1;
    #1;
    chk("orphan sticky1", 96'(err_orphan), 96'(1));
    @(negedge clock);
    #1;
    chk("orphan sticky2", 96'(err_orphan), 96'(1));
    chk("orphan outstanding", 96'(outstanding), 96'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
